// File: rtl/dotproduct_seq.sv
// -----------------------------------------------------------------------------
// dotproduct_seq
//
// Sequential controller for one binarized-neuron evaluation. A neuron's inputs
// and weights are stored as N 6-bit chunks in an external memory. The block
// reads them one per cycle. It forwards each chunk pair to an external
// XNOR/popcount unit, which returns a small signed (sign-magnitude) partial
// score. The block sums these scores on top of a signed bias. It then reports
// the final sum and its sign as the binary activation.
//
// Pipeline seen from the controller:
//   cycle k   : mem_rd_en=1, mem_addr=chunk
//   cycle k+1 : mem_x/mem_w valid, forwarded combinationally on dp_x/dp_w
//   cycle k+2 : dp_y valid, added into the accumulator on the closing edge
//
// Ports
//   sync_clk    in   single clock, rising edge
//   rst         in   asynchronous active-high reset
//   start       in   request an evaluation (sampled only in IDLE)
//   num_chunks  in   chunk count N (clamped to MAXN), sampled with start
//   bias        in   signed accumulator preset, sampled with start
//   mem_rd_en   out  memory read strobe
//   mem_addr    out  chunk index being read
//   mem_x/mem_w in   chunk data, valid the cycle after mem_rd_en
//   dp_x/dp_w   out  operands to the XNOR/popcount unit (= mem_x/mem_w)
//   dp_y        in   unit result, sign-magnitude, valid 1 cycle after dp_x/dp_w
//   busy        out  high whenever the controller is not IDLE
//   done        out  one-cycle result strobe
//   acc_out     out  signed final sum, held until the next done
//   act_out     out  1 when acc_out >= 0, held with acc_out
// -----------------------------------------------------------------------------
module dotproduct_seq #(
  parameter int MAXN = 15  // maximum chunk count per neuron, 1..15
) (
  input  logic       sync_clk,
  input  logic       rst,
  input  logic       start,
  input  logic [3:0] num_chunks,
  input  logic [7:0] bias,
  output logic       mem_rd_en,
  output logic [3:0] mem_addr,
  input  logic [5:0] mem_x,
  input  logic [5:0] mem_w,
  output logic [5:0] dp_x,
  output logic [5:0] dp_w,
  input  logic [3:0] dp_y,
  output logic       busy,
  output logic       done,
  output logic [7:0] acc_out,
  output logic       act_out
);

  localparam logic [3:0] MaxnC = 4'(MAXN);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t            state_q;
  logic [3:0]        n_q;         // latched (clamped) chunk count
  logic [3:0]        addr_q;
  logic              rd_en_q;
  logic              busy_q;
  logic              done_q;
  logic              drain_q;     // second DRAIN cycle marker
  logic              v1_q;        // memory data valid this cycle
  logic              v2_q;        // dp_y valid this cycle
  logic signed [7:0] acc_q;
  logic signed [7:0] acc_d;
  logic [7:0]        acc_out_q;
  logic              act_q;

  logic [3:0]        n_clamped;
  logic signed [7:0] y_mag;
  logic signed [7:0] y_val;

  // Operands go straight through to the XNOR/popcount unit.
  assign dp_x = mem_x;
  assign dp_w = mem_w;

  // ---------------------------------------------------------------------------
  // Combinational helpers: count clamp, dp_y decode, accumulator next value.
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    n_clamped = num_chunks;
    y_mag     = '0;
    y_val     = '0;
    acc_d     = acc_q;

    if (num_chunks > MaxnC) n_clamped = MaxnC;

    // Sign-magnitude decode. Negative zero (4'b1000) negates zero and so
    // decodes as 0 without special handling.
    y_mag = {5'b00000, dp_y[2:0]};
    y_val = dp_y[3] ? -y_mag : y_mag;

    // dp_y is only meaningful when the second pipeline stage is valid.
    // The sum cannot overflow: |bias| <= 37 and N*6 <= 90.
    if (v2_q) acc_d = acc_q + y_val;
  end

  // ---------------------------------------------------------------------------
  // Controller, pipeline valids, accumulator and registered outputs.
  // ---------------------------------------------------------------------------
  // NOTE: all state here is updated with non-blocking assignments so every
  // register samples the pre-edge values of the others, exactly like flops.
  always_ff @(posedge sync_clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      n_q       <= '0;
      addr_q    <= '0;
      rd_en_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      drain_q   <= 1'b0;
      v1_q      <= 1'b0;
      v2_q      <= 1'b0;
      acc_q     <= '0;
      acc_out_q <= '0;
      act_q     <= 1'b0;
    end else begin
      // The valid pipe follows the read strobe in every state.
      v1_q  <= rd_en_q;
      v2_q  <= v1_q;
      acc_q <= acc_d;

      case (state_q)
        IDLE: begin
          if (start) begin
            n_q    <= n_clamped;
            acc_q  <= bias;
            addr_q <= '0;
            busy_q <= 1'b1;
            if (n_clamped == 4'd0) begin
              // Nothing to read: the result is the bias itself.
              state_q   <= DONE;
              done_q    <= 1'b1;
              acc_out_q <= bias;
              act_q     <= ~bias[7];
            end else begin
              state_q <= ISSUE;
              rd_en_q <= 1'b1;
            end
          end
        end

        ISSUE: begin
          if (addr_q == 4'(n_q - 4'd1)) begin
            state_q <= DRAIN;
            rd_en_q <= 1'b0;
            addr_q  <= '0;
            drain_q <= 1'b0;
          end else begin
            addr_q <= addr_q + 4'd1;
          end
        end

        DRAIN: begin
          if (drain_q) begin
            // The last partial score is added on this same edge, so capture
            // the post-add value rather than acc_q.
            state_q   <= DONE;
            done_q    <= 1'b1;
            acc_out_q <= acc_d;
            act_q     <= ~acc_d[7];
          end else begin
            drain_q <= 1'b1;
          end
        end

        DONE: begin
          // start is deliberately not looked at here.
          state_q <= IDLE;
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
        end

        default: begin
          state_q <= IDLE;
          rd_en_q <= 1'b0;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign mem_rd_en = rd_en_q;
  assign mem_addr  = addr_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign acc_out   = acc_out_q;
  assign act_out   = act_q;

endmodule

// File: tb/tb_dotproduct_seq.sv
// -----------------------------------------------------------------------------
// tb_dotproduct_seq
//
// Directed bench for dotproduct_seq. A small responder plays the chunk memory
// (data one cycle after the read strobe) and the XNOR/popcount unit (dp_y one
// cycle after the operands, taken from a per-chunk table). Outside those
// windows dp_y carries a non-zero junk value, so any unqualified accumulation
// shows up in the sum. Expected results are hand-computed constants.
// -----------------------------------------------------------------------------
module tb_dotproduct_seq;

  logic       sync_clk = 1'b0;
  logic       rst      = 1'b1;
  logic       start    = 1'b0;
  logic [3:0] num_chunks = '0;
  logic [7:0] bias     = '0;
  logic       mem_rd_en;
  logic [3:0] mem_addr;
  logic [5:0] mem_x    = '0;
  logic [5:0] mem_w    = '0;
  logic [5:0] dp_x;
  logic [5:0] dp_w;
  logic [3:0] dp_y     = 4'b0111;
  logic       busy;
  logic       done;
  logic [7:0] acc_out;
  logic       act_out;

  dotproduct_seq #(.MAXN(15)) dut (
    .sync_clk  (sync_clk),
    .rst       (rst),
    .start     (start),
    .num_chunks(num_chunks),
    .bias      (bias),
    .mem_rd_en (mem_rd_en),
    .mem_addr  (mem_addr),
    .mem_x     (mem_x),
    .mem_w     (mem_w),
    .dp_x      (dp_x),
    .dp_w      (dp_w),
    .dp_y      (dp_y),
    .busy      (busy),
    .done      (done),
    .acc_out   (acc_out),
    .act_out   (act_out)
  );

  always #5 sync_clk = ~sync_clk;

  // Chunk memory and unit contents.
  logic [5:0] xtab [16];
  logic [5:0] wtab [16];
  logic [3:0] ytab [16];

  // Responder: memory read latency 1, unit latency 1.
  logic       rsp_v1 = 1'b0;
  logic [3:0] rsp_a1 = '0;
  always @(posedge sync_clk) begin
    rsp_v1 <= mem_rd_en;
    rsp_a1 <= mem_addr;
    if (mem_rd_en) begin
      mem_x <= xtab[mem_addr];
      mem_w <= wtab[mem_addr];
    end
    dp_y <= rsp_v1 ? ytab[rsp_a1] : 4'b0111;
  end

  // Observations from the most recent run.
  int         checks = 0;
  int         fails  = 0;
  int         done_cycle;
  int         done_cnt;
  int         rd_cnt;
  int         dp_bad;
  logic [3:0] addr_log [16];
  logic       busy_log [0:31];
  logic [7:0] acc_seen;
  logic       act_seen;

  // Start one evaluation and watch it for max_cycles cycles after the
  // start-sampling edge. Cycle c is observed at the c-th falling edge.
  // With hold_start, start stays high through the DONE cycle.
  task automatic run_eval(input int n, input logic [7:0] b, input int max_cycles,
                          input bit hold_start);
    @(negedge sync_clk);
    num_chunks = 4'(n);
    bias       = b;
    start      = 1'b1;
    @(posedge sync_clk);
    #1;
    if (!hold_start) start = 1'b0;
    done_cycle = -1;
    done_cnt   = 0;
    rd_cnt     = 0;
    dp_bad     = 0;
    acc_seen   = 'x;
    act_seen   = 1'bx;
    for (int i = 0; i < 32; i++) busy_log[i] = 1'b0;
    for (int c = 1; c <= max_cycles; c++) begin
      @(negedge sync_clk);
      busy_log[c] = busy;
      if (mem_rd_en) begin
        if (rd_cnt < 16) addr_log[rd_cnt] = mem_addr;
        rd_cnt++;
      end
      if (dp_x !== mem_x || dp_w !== mem_w) dp_bad++;
      if (done) begin
        done_cnt++;
        if (done_cycle < 0) begin
          done_cycle = c;
          acc_seen   = acc_out;
          act_seen   = act_out;
        end
      end
      if (hold_start && c >= n + 4) start = 1'b0;
    end
    start = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    checks++;
    if ({busy, done, mem_rd_en} !== 3'b000) begin
      fails++;
      $display("FAIL %s ctl: busy/done/rd_en=%b%b%b expected 000", tag, busy, done, mem_rd_en);
    end
    checks++;
    if (mem_addr !== 4'h0) begin
      fails++;
      $display("FAIL %s mem_addr: got %h expected 0", tag, mem_addr);
    end
    checks++;
    if (acc_out !== 8'h00 || act_out !== 1'b0) begin
      fails++;
      $display("FAIL %s result: acc_out=%h act_out=%b expected 00/0", tag, acc_out, act_out);
    end
  endtask

  task automatic test_reset;
    #2;
    check_reset_outputs("reset");
    @(negedge sync_clk);
    rst = 1'b0;
    @(negedge sync_clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      fails++;
      $display("FAIL reset_idle: busy=%b done=%b expected 0/0", busy, done);
    end
  endtask

  task automatic test_single;
    xtab[0] = 6'b000000; wtab[0] = 6'b000000; ytab[0] = 4'b0110;
    run_eval(1, 8'h00, 9, 1'b0);
    checks++;
    if (done_cycle !== 4) begin
      fails++; $display("FAIL single_latency: done cycle %0d expected 4", done_cycle);
    end
    checks++;
    if (acc_seen !== 8'h06 || act_seen !== 1'b1) begin
      fails++; $display("FAIL single_result: acc=%h act=%b expected 06/1", acc_seen, act_seen);
    end
    checks++;
    if (done_cnt !== 1) begin
      fails++; $display("FAIL single_done_count: %0d expected 1", done_cnt);
    end
  endtask

  task automatic test_negative;
    xtab[0] = 6'b101010; xtab[1] = 6'b110011; xtab[2] = 6'b000111;
    for (int i = 0; i < 3; i++) begin
      wtab[i] = ~xtab[i];
      ytab[i] = 4'b1110;
    end
    run_eval(3, 8'h05, 11, 1'b0);
    checks++;
    if (acc_seen !== 8'hF3 || act_seen !== 1'b0) begin
      fails++; $display("FAIL negative_result: acc=%h act=%b expected f3/0", acc_seen, act_seen);
    end
    checks++;
    if (done_cycle !== 6) begin
      fails++; $display("FAIL negative_latency: done cycle %0d expected 6", done_cycle);
    end
    checks++;
    if (rd_cnt !== 3) begin
      fails++; $display("FAIL negative_reads: %0d reads expected 3", rd_cnt);
    end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (addr_log[i] !== 4'(i)) begin
        fails++; $display("FAIL negative_addr%0d: got %h expected %h", i, addr_log[i], 4'(i));
      end
    end
    checks++;
    if (dp_bad !== 0) begin
      fails++; $display("FAIL operand_forward: %0d cycles with dp_x/dp_w != mem_x/mem_w", dp_bad);
    end
  endtask

  task automatic test_zero_chunks;
    run_eval(0, 8'hFF, 5, 1'b0);
    checks++;
    if (rd_cnt !== 0) begin
      fails++; $display("FAIL zero_reads: %0d reads expected 0", rd_cnt);
    end
    checks++;
    if (done_cycle !== 1) begin
      fails++; $display("FAIL zero_latency: done cycle %0d expected 1", done_cycle);
    end
    checks++;
    if (acc_seen !== 8'hFF || act_seen !== 1'b0) begin
      fails++; $display("FAIL zero_result: acc=%h act=%b expected ff/0", acc_seen, act_seen);
    end
  endtask

  task automatic test_full;
    int busy_hi;
    for (int i = 0; i < 16; i++) begin
      xtab[i] = 6'(i * 3); wtab[i] = 6'(i * 3); ytab[i] = 4'b0110;
    end
    run_eval(15, 8'h00, 22, 1'b0);
    busy_hi = 0;
    for (int c = 1; c <= 17; c++) if (busy_log[c] === 1'b1) busy_hi++;
    checks++;
    if (acc_seen !== 8'h5A || act_seen !== 1'b1) begin
      fails++; $display("FAIL full_result: acc=%h act=%b expected 5a/1", acc_seen, act_seen);
    end
    checks++;
    if (done_cycle !== 18) begin
      fails++; $display("FAIL full_latency: done cycle %0d expected 18", done_cycle);
    end
    checks++;
    if (busy_hi !== 17) begin
      fails++; $display("FAIL full_busy: busy high in %0d of cycles 1..17 expected 17", busy_hi);
    end
    checks++;
    if (busy_log[19] !== 1'b0) begin
      fails++; $display("FAIL full_idle: busy in cycle 19 = %b expected 0", busy_log[19]);
    end
  endtask

  task automatic test_neg_zero;
    ytab[0] = 4'b0000; ytab[1] = 4'b1000;
    run_eval(2, 8'h00, 10, 1'b0);
    checks++;
    if (acc_seen !== 8'h00 || act_seen !== 1'b1) begin
      fails++; $display("FAIL neg_zero_result: acc=%h act=%b expected 00/1", acc_seen, act_seen);
    end
  endtask

  task automatic test_mixed_signs;
    // -10 + 5 - 3 + 7 - 1 = -2
    ytab[0] = 4'b0101; ytab[1] = 4'b1011; ytab[2] = 4'b0111; ytab[3] = 4'b1001;
    run_eval(4, 8'hF6, 12, 1'b0);
    checks++;
    if (acc_seen !== 8'hFE || act_seen !== 1'b0) begin
      fails++; $display("FAIL mixed_result: acc=%h act=%b expected fe/0", acc_seen, act_seen);
    end
    checks++;
    if (acc_out !== 8'hFE || act_out !== 1'b0) begin
      fails++; $display("FAIL mixed_hold: acc_out=%h act_out=%b expected fe/0", acc_out, act_out);
    end
  endtask

  task automatic test_back_to_back;
    // start held high while busy and through DONE must not launch a second run.
    ytab[0] = 4'b0001; ytab[1] = 4'b0010;
    run_eval(2, 8'h03, 10, 1'b1);
    checks++;
    if (done_cnt !== 1) begin
      fails++; $display("FAIL busy_start_done_count: %0d expected 1", done_cnt);
    end
    checks++;
    if (done_cycle !== 5 || acc_seen !== 8'h06) begin
      fails++; $display("FAIL busy_start_result: cycle %0d acc=%h expected 5/06", done_cycle, acc_seen);
    end
    checks++;
    if (rd_cnt !== 2) begin
      fails++; $display("FAIL busy_start_reads: %0d expected 2", rd_cnt);
    end
    ytab[0] = 4'b1111;
    run_eval(1, 8'h00, 8, 1'b0);
    checks++;
    if (done_cycle !== 4 || acc_seen !== 8'hF9 || act_seen !== 1'b0) begin
      fails++;
      $display("FAIL next_run: cycle %0d acc=%h act=%b expected 4/f9/0", done_cycle, acc_seen, act_seen);
    end
  endtask

  task automatic test_reset_abort;
    int stray_done;
    int stray_rd;
    for (int i = 0; i < 16; i++) ytab[i] = 4'b0110;
    @(negedge sync_clk);
    num_chunks = 4'd5;
    bias       = 8'h10;
    start      = 1'b1;
    @(posedge sync_clk);
    #1;
    start = 1'b0;
    @(negedge sync_clk);
    @(negedge sync_clk);
    checks++;
    if (mem_rd_en !== 1'b1 || busy !== 1'b1) begin
      fails++; $display("FAIL abort_pre: rd_en=%b busy=%b expected 1/1", mem_rd_en, busy);
    end
    rst = 1'b1;
    #1;
    check_reset_outputs("abort_reset");
    @(negedge sync_clk);
    rst = 1'b0;
    stray_done = 0;
    stray_rd   = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge sync_clk);
      if (done) stray_done++;
      if (mem_rd_en || busy) stray_rd++;
    end
    checks++;
    if (stray_done !== 0 || stray_rd !== 0) begin
      fails++;
      $display("FAIL abort_quiet: %0d done, %0d busy/read cycles expected 0/0", stray_done, stray_rd);
    end
    ytab[0] = 4'b0011;
    run_eval(1, 8'hFB, 9, 1'b0);
    checks++;
    if (done_cycle !== 4 || done_cnt !== 1) begin
      fails++; $display("FAIL abort_rerun_timing: cycle %0d count %0d expected 4/1", done_cycle, done_cnt);
    end
    checks++;
    if (acc_seen !== 8'hFE || act_seen !== 1'b0) begin
      fails++; $display("FAIL abort_rerun_result: acc=%h act=%b expected fe/0", acc_seen, act_seen);
    end
  endtask

  initial begin
    for (int i = 0; i < 16; i++) begin
      xtab[i] = '0; wtab[i] = '0; ytab[i] = 4'b0000;
    end
    test_reset;
    test_single;
    test_negative;
    test_zero_chunks;
    test_full;
    test_neg_zero;
    test_mixed_signs;
    test_back_to_back;
    test_reset_abort;
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/dotproduct_seq.md
DOTPRODUCT_SEQ -- requirements
Module: dotproduct_seq

Interface
REQ-001 SHALL have parameter MAXN, default 15, giving the maximum chunk count per neuron; legal range 1..15.
REQ-002 SHALL have port sync_clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-004 SHALL have port start, input, 1 bit: request one neuron evaluation; sampled only in IDLE.
REQ-005 SHALL have port num_chunks, input, 4 bits: number of 6-bit chunks N, sampled with start.
REQ-006 SHALL have port bias, input, 8 bits: signed two's-complement accumulator preset, sampled with start.
REQ-007 SHALL have port mem_rd_en, output, 1 bit: weight/activation memory read strobe.
REQ-008 SHALL have port mem_addr, output, 4 bits: chunk index being read.
REQ-009 SHALL have ports mem_x and mem_w, inputs, 6 bits each: chunk data, valid in the cycle after mem_rd_en.
REQ-010 SHALL have ports dp_x and dp_w, outputs, 6 bits each: operands to the XNOR/popcount unit, driven combinationally from mem_x and mem_w.
REQ-011 SHALL have port dp_y, input, 4 bits: unit result in sign-magnitude form; bit3 is the sign, bits2:0 the magnitude; valid 1 cycle after dp_x/dp_w.
REQ-012 SHALL have port busy, output, 1 bit: high in every state except IDLE.
REQ-013 SHALL have port done, output, 1 bit: one-cycle pulse marking a result.
REQ-014 SHALL have port acc_out, output, 8 bits: signed final sum, held until the next done.
REQ-015 SHALL have port act_out, output, 1 bit: binarized activation, 1 when acc_out >= 0; held with acc_out.

Function
REQ-016 SHALL implement the states IDLE, ISSUE, DRAIN and DONE.
REQ-017 IDLE with start=1 SHALL latch N and bias, load acc=bias and mem_addr=0, then go to ISSUE; if N=0 it SHALL go directly to DONE instead.
REQ-018 ISSUE SHALL assert mem_rd_en with mem_addr=0,1,...,N-1 over N consecutive cycles, then go to DRAIN.
REQ-019 DRAIN SHALL last exactly 2 cycles with mem_rd_en=0, then go to DONE.
REQ-020 SHALL track the pipeline with a 2-stage valid shift register; stage 2 high SHALL add the decoded dp_y into acc on that edge.
REQ-021 SHALL decode dp_y as value = +dp_y[2:0] when dp_y[3]=0 and -dp_y[2:0] when dp_y[3]=1; 4'b1000 (negative zero) SHALL decode as 0.
REQ-022 SHALL use an 8-bit signed acc without saturation; the range is guaranteed because |bias| <= 37 and N*6 <= 90.
REQ-023 On entry to DONE it SHALL load acc_out=acc and act_out=~acc[7], assert done for exactly 1 cycle, then return to IDLE.
REQ-024 done SHALL appear in the (N+3)th cycle after the start-sampling edge, or in the 1st cycle when N=0.
REQ-025 start while busy=1 SHALL be ignored, with no queuing.
REQ-026 start held high in the DONE cycle SHALL have no effect; a new evaluation begins only from IDLE, so the minimum spacing is N+4 cycles.
REQ-027 num_chunks > MAXN SHALL be clamped to MAXN.
REQ-028 dp_y SHALL be ignored whenever stage-2 valid is low.

Reset
REQ-029 rst=1 SHALL force IDLE at any time, including mid-ISSUE or mid-DRAIN, and SHALL clear the pipeline valids and acc.
REQ-030 rst=1 SHALL drive busy=0, done=0, mem_rd_en=0, mem_addr=0, acc_out=8'h00 and act_out=0 immediately.
REQ-031 After rst deasserts, the first start in IDLE SHALL run normally; no partial result from an aborted run SHALL appear.

Verification
REQ-032 Case N=1, bias=0, mem_x=mem_w=6'b000000, dp_y=4'b0110: done in cycle 4, acc_out=8'h06, act_out=1.
REQ-033 Case N=3, bias=5, mem_x=~mem_w, dp_y=4'b1110 each: acc_out=8'hF3 (-13), act_out=0, mem_addr sequence 0,1,2.
REQ-034 Case N=0, bias=8'hFF: mem_rd_en never asserts, done in cycle 1, acc_out=8'hFF, act_out=0.
REQ-035 Case N=15, bias=0, all chunks matching (dp_y=4'b0110): acc_out=8'h5A, done in cycle 18, busy high in cycles 1..17.
REQ-036 Case dp_y=4'b0000 and 4'b1000 mixed in with N=2, bias=0: acc_out=8'h00, act_out=1.
REQ-037 Case rst pulsed mid-ISSUE of an N=5 run, then start with N=1: no done from the aborted run, second run correct; a start asserted while busy produces no extra done.
